// File: rtl/rpi_gpio_debounce.sv
// Conditions raw RPi GPIO pins: per-bit synchronizer, stable-count debounce,
// registered rise/fall strobes and a coalescing valid/ready change-event record.
module rpi_gpio_debounce #(
    parameter int   NUM_BITS        = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] rpi_in,
    output logic [NUM_BITS-1:0] gpio_clean,
    output logic [NUM_BITS-1:0] gpio_rise,
    output logic [NUM_BITS-1:0] gpio_fall,
    output logic                evt_valid,
    output logic [NUM_BITS-1:0] evt_data,
    input  logic                evt_ready,
    output logic                evt_overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][NUM_BITS-1:0] sync_chain;
    logic [NUM_BITS-1:0]                  sync_bits;
    logic [CNT_W-1:0]                     cnt_q [NUM_BITS];
    logic [CNT_W-1:0]                     cnt_d [NUM_BITS];
    logic [NUM_BITS-1:0]                  accept;
    logic                                 chg;

    assign sync_bits = sync_chain[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain <= {SYNC_STAGES{ {NUM_BITS{RESET_LEVEL}} }};
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], rpi_in};
        end
    end

    // Any synchronized cycle that agrees with the clean level restarts the count.
    always_comb begin
        for (int i = 0; i < NUM_BITS; i++) begin
            accept[i] = 1'b0;
            cnt_d[i]  = cnt_q[i];
            if (sync_bits[i] == gpio_clean[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                accept[i] = 1'b1;
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BITS; i++) begin
                cnt_q[i] <= '0;
            end
            gpio_clean <= {NUM_BITS{RESET_LEVEL}};
            gpio_rise  <= '0;
            gpio_fall  <= '0;
        end else begin
            for (int i = 0; i < NUM_BITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            gpio_clean <= gpio_clean ^ accept;
            gpio_rise  <= accept & sync_bits;
            gpio_fall  <= accept & ~sync_bits;
        end
    end

    // Event handshake: a record transfers on a clk edge where evt_valid and
    // evt_ready are both high; while stalled evt_valid/evt_data hold, except a
    // new change overwrites evt_data with the latest levels and sets evt_overflow.
    assign chg = |(gpio_rise | gpio_fall);

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid    <= 1'b0;
            evt_data     <= {NUM_BITS{RESET_LEVEL}};
            evt_overflow <= 1'b0;
        end else if (chg) begin
            evt_valid <= 1'b1;
            evt_data  <= gpio_clean;
            if (evt_valid && !evt_ready) begin
                evt_overflow <= 1'b1;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rpi_gpio_debounce.sv
// Bench for rpi_gpio_debounce: directed steps followed by random pin activity,
// every cycle compared against a sample-history model of the debounce rules.
module tb_rpi_gpio_debounce;

    localparam int NB = 4;
    localparam int SS = 2;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] rpi_in;
    logic [NB-1:0] gpio_clean;
    logic [NB-1:0] gpio_rise;
    logic [NB-1:0] gpio_fall;
    logic          evt_valid;
    logic [NB-1:0] evt_data;
    logic          evt_ready;
    logic          evt_overflow;

    rpi_gpio_debounce #(
        .NUM_BITS(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .rpi_in(rpi_in),
        .gpio_clean(gpio_clean), .gpio_rise(gpio_rise), .gpio_fall(gpio_fall),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // One entry per clock edge: the pin value sampled at that edge (0 under reset).
    logic [NB-1:0] samp_q[$];
    logic [NB-1:0] m_clean, m_rise, m_fall, m_data;
    logic          m_valid, m_ovf;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A level is accepted once the last DC synchronized values all oppose the clean level;
    // the synchronized value seen at edge n is the pin sample from edge n-SS.
    task automatic model_step();
        int n;
        logic [NB-1:0] acc;
        logic held;
        if (reset) begin
            for (int k = 1; k < SS; k++) begin
                if (samp_q.size() >= k) samp_q[samp_q.size() - k] = '0;
            end
            samp_q.push_back('0);
            m_clean = '0; m_rise = '0; m_fall = '0;
            m_valid = 1'b0; m_data = '0; m_ovf = 1'b0;
        end else begin
            samp_q.push_back(rpi_in);
            n = samp_q.size() - 1;
            if (|(m_rise | m_fall)) begin
                if (m_valid && !evt_ready) m_ovf = 1'b1;
                m_valid = 1'b1;
                m_data  = m_clean;
            end else if (m_valid && evt_ready) begin
                m_valid = 1'b0;
            end
            acc = '0;
            for (int i = 0; i < NB; i++) begin
                if (n - SS - DC + 1 >= 0) begin
                    held = 1'b1;
                    for (int j = 0; j < DC; j++) begin
                        if (samp_q[n - SS - j][i] == m_clean[i]) held = 1'b0;
                    end
                    acc[i] = held;
                end
            end
            m_rise  = acc & ~m_clean;
            m_fall  = acc & m_clean;
            m_clean = m_clean ^ acc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("clean", gpio_clean, m_clean);
        check("rise", gpio_rise, m_rise);
        check("fall", gpio_fall, m_fall);
        check("evt_valid", {3'b0, evt_valid}, {3'b0, m_valid});
        check("evt_data", evt_data, m_data);
        check("evt_overflow", {3'b0, evt_overflow}, {3'b0, m_ovf});
        check("strobe_excl", gpio_rise & gpio_fall, 4'h0);
    endtask

    initial begin
        logic saw;
        int   rises;
        int   rise_at;
        int   seg;
        int   cycles;

        // 1: reset with pins high, then 10 edges to acceptance
        reset = 1'b1; rpi_in = 4'hF; evt_ready = 1'b1;
        tick(); tick();
        check("t1_reset_clean", gpio_clean, 4'h0);
        check("t1_reset_valid", {3'b0, evt_valid}, 4'h0);
        reset = 1'b0;
        repeat (9) tick();
        check("t1_clean_early", gpio_clean, 4'h0);
        tick();
        check("t1_clean", gpio_clean, 4'hF);
        check("t1_rise", gpio_rise, 4'hF);
        tick();
        check("t1_rise_once", gpio_rise, 4'h0);
        check("t1_evt_valid", {3'b0, evt_valid}, 4'h1);
        check("t1_evt_data", evt_data, 4'hF);
        rpi_in = 4'h0;
        repeat (12) tick();
        check("t1_back_low", gpio_clean, 4'h0);
        check("t1_evt_drained", {3'b0, evt_valid}, 4'h0);

        // 2: glitch of 7 cycles rejected, then 12-cycle hold accepted
        saw = 1'b0;
        for (int k = 0; k < 22; k++) begin
            rpi_in[0] = (k < 7);
            tick();
            saw = saw | evt_valid | gpio_rise[0] | gpio_clean[0];
        end
        check("t2_glitch", {3'b0, saw}, 4'h0);
        rises = 0;
        rpi_in[0] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            rises += int'(gpio_rise[0]);
        end
        check_int("t2_single_rise", rises, 1);
        check("t2_clean", gpio_clean, 4'h1);

        // 3: bit 2 bounces every 3 cycles, then settles high
        rises = 0;
        for (int k = 0; k < 30; k++) begin
            rpi_in[2] = ((k / 3) % 2 == 0);
            tick();
            rises += int'(gpio_rise[2]);
        end
        rpi_in[2] = 1'b1;
        rise_at = -1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (gpio_rise[2]) begin
                rises++;
                rise_at = k;
            end
        end
        check_int("t3_rise_count", rises, 1);
        check_int("t3_rise_edge", rise_at, 10);
        check("t3_clean", gpio_clean, 4'h5);

        // 4: backpressure coalescing and sticky overflow
        rpi_in = 4'h0;
        repeat (14) tick();
        evt_ready = 1'b0;
        rpi_in = 4'b0010;
        repeat (12) tick();
        check("t4_first_valid", {3'b0, evt_valid}, 4'h1);
        check("t4_no_ovf_yet", {3'b0, evt_overflow}, 4'h0);
        rpi_in = 4'b1010;
        repeat (12) tick();
        check("t4_valid", {3'b0, evt_valid}, 4'h1);
        check("t4_data", evt_data, 4'b1010);
        check("t4_ovf", {3'b0, evt_overflow}, 4'h1);
        evt_ready = 1'b1;
        tick();
        check("t4_drop", {3'b0, evt_valid}, 4'h0);
        check("t4_ovf_sticky", {3'b0, evt_overflow}, 4'h1);

        // 5: falling count interrupted by reset
        rpi_in = 4'h1;
        repeat (14) tick();
        check("t5_start", gpio_clean, 4'h1);
        rpi_in = 4'h0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        check("t5_clean", gpio_clean, 4'h0);
        check("t5_fall", gpio_fall, 4'h0);
        check("t5_ovf", {3'b0, evt_overflow}, 4'h0);
        reset = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            tick();
            saw = saw | (|gpio_fall) | evt_valid;
        end
        check("t5_quiet", {3'b0, saw}, 4'h0);

        // 6: two bits accepted together form one event
        rpi_in = 4'h5;
        repeat (9) tick();
        check("t6_early", gpio_rise, 4'h0);
        tick();
        check("t6_rise", gpio_rise, 4'h5);
        tick();
        check("t6_rise_once", gpio_rise, 4'h0);
        check("t6_valid", {3'b0, evt_valid}, 4'h1);
        check("t6_data", evt_data, 4'h5);
        tick();
        check("t6_single_evt", {3'b0, evt_valid}, 4'h0);

        // random pins, hold lengths, ready and occasional reset
        cycles = 0;
        while (cycles < 1500) begin
            rpi_in = 4'($urandom_range(0, 15));
            reset  = ($urandom_range(0, 49) == 0);
            seg    = $urandom_range(1, 14);
            for (int k = 0; k < seg; k++) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                if (k == 0 && reset) begin
                    tick();
                    reset = 1'b0;
                end else begin
                    if ($urandom_range(0, 9) == 0) rpi_in = rpi_in ^ 4'(1 << $urandom_range(0, 3));
                    tick();
                end
                cycles++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rpi_gpio_debounce.md
Name: rpi_gpio_debounce

Overview:
- Upstream conditioning stage for the RPi-driven GPIO inputs. It sits between the raw asynchronous rpi_in pins and any consumer, such as the LED output stage or control logic.
- It synchronizes each bit into clk and debounces it with a per-bit stable-count filter. It then emits clean levels, single-cycle rise/fall strobes, and a valid/ready change-event record.
- Without this stage, pin glitches and metastability would reach the LEDs and the FSMs.

Parameters:
- NUM_BITS, 4: number of GPIO lines conditioned.
- SYNC_STAGES, 2: synchronizer flop depth per bit. Minimum 2.
- DEBOUNCE_CYCLES, 1000: consecutive synchronized cycles a new level must hold before it is accepted. Minimum 2.
- RESET_LEVEL, 0: value loaded into the synchronizer and clean registers at reset. Applies to all bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rpi_in  input  NUM_BITS  raw asynchronous pins from the RPi.
- gpio_clean  output  NUM_BITS  debounced levels (drive to led_out downstream).
- gpio_rise  output  NUM_BITS  one-cycle strobe per bit on an accepted 0->1.
- gpio_fall  output  NUM_BITS  one-cycle strobe per bit on an accepted 1->0.
- evt_valid  output  1  change event pending.
- evt_data  output  NUM_BITS  gpio_clean snapshot for the pending event.
- evt_ready  input  1  consumer accepts the event when evt_valid and evt_ready are both high.
- evt_overflow  output  1  sticky flag: a change occurred while an event was stalled.

Behaviour:
- Reset: one clock is used and reset is synchronous and active-high.
  - While reset is high at a clk edge, all of the following are loaded: sync chain = {NUM_BITS{RESET_LEVEL}}, gpio_clean = {NUM_BITS{RESET_LEVEL}}, debounce counters = 0, gpio_rise/gpio_fall = 0, evt_valid = 0, evt_data = {NUM_BITS{RESET_LEVEL}}, evt_overflow = 0.
  - Reset mid-count discards the partial count. The first post-reset cycle produces no strobes.
- Synchronizer: per-bit chain of SYNC_STAGES flops. sync[i] is the last stage.
- Debounce, per bit i, independent of the other bits; counter width is clog2(DEBOUNCE_CYCLES):
  - If sync[i] == gpio_clean[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: gpio_clean[i] <= sync[i], cnt[i] <= 0, and strobe asserted.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles resets the count and never changes gpio_clean.
- Strobes: gpio_rise[i]/gpio_fall[i] are registered and high in exactly the cycle gpio_clean[i] first shows the new value. They are low otherwise and never both high for the same bit.
- Latency: a clean step on rpi_in[i] that is sampled at edge 0 reaches sync[i] after SYNC_STAGES edges. It appears on gpio_clean[i] DEBOUNCE_CYCLES edges after that, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges total.
- Event channel: let chg = |(gpio_rise|gpio_fall), registered alongside gpio_clean.
  - chg && (!evt_valid || evt_ready): evt_valid <= 1, evt_data <= current gpio_clean.
  - chg && evt_valid && !evt_ready: evt_data <= current gpio_clean (coalesce to the latest state), evt_valid stays 1, evt_overflow <= 1.
  - !chg && evt_valid && evt_ready: evt_valid <= 0, evt_data holds.
  - evt_valid and evt_data are stable while evt_valid && !evt_ready, except when coalescing on a new change.
- Simultaneous events: several bits accepted in the same cycle produce one event carrying all of the new levels.
- evt_overflow clears only on reset.
- No combinational path from any input to any output.

Test Plan:
(Simulation uses DEBOUNCE_CYCLES=8, SYNC_STAGES=2, RESET_LEVEL=0, evt_ready=1 unless stated.)
1. Reset: hold rpi_in=4'hF during reset, then release -> gpio_clean=0 after reset. gpio_clean=4'hF exactly 10 edges after the first post-reset sample, with gpio_rise=4'hF for one cycle and one event with evt_data=4'hF.
2. Glitch rejection: rpi_in[0] pulses high for 7 cycles, then low -> gpio_clean stays 0, no strobe, evt_valid never asserts. The same pulse held for 8+ cycles -> gpio_clean[0]=1 with a single gpio_rise[0].
3. Bounce: rpi_in[2] toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one gpio_rise[2], 10 edges after the final transition.
4. Backpressure: evt_ready=0, bit 1 accepted high, then bit 3 accepted high -> evt_valid=1, evt_data=4'b1010, evt_overflow=1. Raise evt_ready -> evt_valid drops the next cycle, and evt_overflow stays 1.
5. Falling edge plus reset mid-count: from gpio_clean=4'h1, drive rpi_in[0]=0 and assert reset at count 5 -> gpio_clean=0, no gpio_fall strobe, cnt=0, evt_overflow=0.
6. Simultaneous: rpi_in 4'h0 -> 4'h5 in one cycle -> gpio_rise=4'h5 in the same single cycle, one event with evt_data=4'h5.
